cond_unit: RTL and testbench

Execute-to-memory condition stage that consumes the ALU's `{N,Z,C,V}` flag output. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags. It gates register-write, memory-write and PC-source controls, and registers the gated controls into the memory stage with stall and flush support. It sits directly downstream of the ALU in the pipelined datapath.

---
 rtl/cond_unit_if.sv | 32 +++
 rtl/cond_unit.sv | 97 +++++++++
 tb/tb_cond_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cond_unit_if.sv
// Execute-stage condition/flag interface between the E-stage driver and cond_unit.
// The master drives the E-stage controls. The slave returns the condition result and the M-stage controls.
interface cond_unit_if;
  logic       stall;
  logic       flush;
  logic       valid_e;
  logic [3:0] cond_e;
  logic [3:0] alu_flags;
  logic [1:0] flag_w_e;
  logic       pcs_e;
  logic       reg_w_e;
  logic       mem_w_e;
  logic       no_write_e;
  logic       cond_ex_e;
  logic [3:0] flags;
  logic       valid_m;
  logic       pc_src_m;
  logic       reg_write_m;
  logic       mem_write_m;

  modport master (
    output stall, flush, valid_e, cond_e, alu_flags, flag_w_e,
    output pcs_e, reg_w_e, mem_w_e, no_write_e,
    input  cond_ex_e, flags, valid_m, pc_src_m, reg_write_m, mem_write_m
  );

  modport slave (
    input  stall, flush, valid_e, cond_e, alu_flags, flag_w_e,
    input  pcs_e, reg_w_e, mem_w_e, no_write_e,
    output cond_ex_e, flags, valid_m, pc_src_m, reg_write_m, mem_write_m
  );
endinterface

// File: rtl/cond_unit.sv
// E-to-M condition stage: holds the NZCV register and evaluates the instruction condition field.
// It gates the write/PC controls and registers them into M, with stall and flush support.
module cond_unit (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);

  typedef enum logic [3:0] {
    CondEq = 4'b0000, CondNe = 4'b0001, CondCs = 4'b0010, CondCc = 4'b0011,
    CondMi = 4'b0100, CondPl = 4'b0101, CondVs = 4'b0110, CondVc = 4'b0111,
    CondHi = 4'b1000, CondLs = 4'b1001, CondGe = 4'b1010, CondLt = 4'b1011,
    CondGt = 4'b1100, CondLe = 4'b1101, CondAl = 4'b1110, CondNv = 4'b1111
  } cond_e_t;

  logic [3:0] flags_q, flags_d;
  logic       valid_q, valid_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;

  logic n, z, c, v;
  logic cond_ex;
  logic go;

  assign {n, z, c, v} = flags_q;

  // Evaluated against the stored flags, never the in-flight ALU flags.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_e_t'(bus.cond_e))
      CondEq: cond_ex = z;
      CondNe: cond_ex = ~z;
      CondCs: cond_ex = c;
      CondCc: cond_ex = ~c;
      CondMi: cond_ex = n;
      CondPl: cond_ex = ~n;
      CondVs: cond_ex = v;
      CondVc: cond_ex = ~v;
      CondHi: cond_ex = c & ~z;
      CondLs: cond_ex = ~c | z;
      CondGe: cond_ex = (n == v);
      CondLt: cond_ex = (n != v);
      CondGt: cond_ex = ~z & (n == v);
      CondLe: cond_ex = z | (n != v);
      CondAl: cond_ex = 1'b1;
      CondNv: cond_ex = 1'b0;
    endcase
  end

  assign go = bus.valid_e & cond_ex & ~bus.flush & ~bus.stall;

  always_comb begin
    flags_d     = flags_q;
    valid_d     = valid_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;

    if (go) begin
      if (bus.flag_w_e[1]) flags_d[3:2] = bus.alu_flags[3:2];
      if (bus.flag_w_e[0]) flags_d[1:0] = bus.alu_flags[1:0];
    end

    // Flush wins over stall: a squashed instruction must not linger in M.
    if (bus.flush || !bus.stall) begin
      valid_d     = go;
      pc_src_d    = go & bus.pcs_e;
      reg_write_d = go & bus.reg_w_e & ~bus.no_write_e;
      mem_write_d = go & bus.mem_w_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      valid_q     <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.cond_ex_e   = cond_ex;
  assign bus.flags       = flags_q;
  assign bus.valid_m     = valid_q;
  assign bus.pc_src_m    = pc_src_q;
  assign bus.reg_write_m = reg_write_q;
  assign bus.mem_write_m = mem_write_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit.
// It uses hand-computed expected values and checks them with immediate assertions.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cond_unit_if bus ();

  cond_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] cnd, input logic [3:0] af,
                       input logic [1:0] fw, input logic pcs, input logic rw,
                       input logic mw, input logic nw);
    bus.valid_e    = vld;
    bus.cond_e     = cnd;
    bus.alu_flags  = af;
    bus.flag_w_e   = fw;
    bus.pcs_e      = pcs;
    bus.reg_w_e    = rw;
    bus.mem_w_e    = mw;
    bus.no_write_e = nw;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // M outputs packed as {valid_m, pc_src_m, reg_write_m, mem_write_m}.
  task automatic check_m(input string tag, input logic [3:0] exp);
    check(tag, {bus.valid_m, bus.pc_src_m, bus.reg_write_m, bus.mem_write_m}, exp);
  endtask

  task automatic check_conds(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      bus.cond_e = 4'(i);
      #1;
      check($sformatf("%s_cond%0d", tag, i), bus.cond_ex_e, exp[i]);
    end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    check("reset_flags", bus.flags, 4'b0000);
    check_m("reset_m", 4'b0000);

    // AL with register write, no flag update.
    drive(1'b1, 4'b1110, 4'b1111, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("al_cond", bus.cond_ex_e, 1'b1);
    tick;
    check_m("al_m", 4'b1010);
    check("al_flags", bus.flags, 4'b0000);

    // Flag-setting instruction immediately followed by EQ.
    drive(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("set_flags", bus.flags, 4'b0100);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("eq_cond", bus.cond_ex_e, 1'b1);
    tick;
    check_m("eq_m", 4'b1001);
    drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("ne_cond", bus.cond_ex_e, 1'b0);
    tick;
    check_m("ne_m", 4'b0000);

    // Partial update: N,Z only.
    drive(1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("flags_1001", bus.flags, 4'b1001);
    drive(1'b1, 4'b1110, 4'b0110, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("partial_nz", bus.flags, 4'b0101);
    drive(1'b0, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("invalid_no_update", bus.flags, 4'b0101);
    // N=0 Z=1 C=0 V=1: GE fails, LT passes.
    check_conds("f0101", 16'h6A69);

    // Compare-type instruction suppresses the register write.
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    tick;
    check_m("cmp_m", 4'b1000);

    // Load M, then stall for three cycles with a flag-setting instruction on E.
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    check_m("pre_stall_m", 4'b1110);
    bus.stall = 1'b1;
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("stall%0d_flags", i), bus.flags, 4'b0101);
      check_m($sformatf("stall%0d_m", i), 4'b1110);
    end
    bus.flush = 1'b1;
    tick;
    check("flush_stall_flags", bus.flags, 4'b0101);
    check_m("flush_stall_m", 4'b0000);
    bus.stall = 1'b0;
    tick;
    check("flush_only_flags", bus.flags, 4'b0101);
    check_m("flush_only_m", 4'b0000);
    bus.flush = 1'b0;

    // Full flag update, then the condition table against two more flag patterns.
    drive(1'b1, 4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("flags_1010", bus.flags, 4'b1010);
    bus.valid_e = 1'b0;
    check_conds("f1010", 16'h6996);
    drive(1'b1, 4'b1110, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("flags_0010", bus.flags, 4'b0010);
    bus.valid_e = 1'b0;
    check_conds("f0010", 16'h55A6);

    // C,V-only update keeps N,Z.
    drive(1'b1, 4'b1110, 4'b1101, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    check("partial_cv", bus.flags, 4'b0001);

    // Reserved condition never executes.
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    check_m("all_set_m", 4'b1111);
    drive(1'b1, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("nv_cond", bus.cond_ex_e, 1'b0);
    tick;
    check_m("nv_m", 4'b0000);
    check("nv_flags", bus.flags, 4'b0001);

    // Reset mid-stream overrides stall and discards the in-flight instruction.
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    check_m("pre_reset_m", 4'b1111);
    reset = 1'b1;
    bus.stall = 1'b1;
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    check_m("midreset_m", 4'b0000);
    check("midreset_flags", bus.flags, 4'b0000);
    reset = 1'b0;
    bus.stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
